// File: rtl/audio_pkg.sv
// audio_pkg: shared constants and types for the WM8750 DSP-mode serial port.
//   CLK12_HZ / FS_48K_FRAME_CLKS : clock and default frame length
//   FORMAT_DSP / LRP_B / MS_MASTER : WM8750 audio-interface register fields
//   slot_ctl_t : per-cycle strobes from the frame timer to the datapaths
//   frame_clks(fs) : clk12 cycles per frame for a sample rate
package audio_pkg;

    localparam int CLK12_HZ          = 12000000;
    localparam int FS_48K_FRAME_CLKS = 250;

    // WM8750 R7 (audio interface) fields
    localparam logic [1:0] FORMAT_DSP = 2'd3;
    localparam logic       LRP_B      = 1'b1;
    localparam logic       MS_MASTER  = 1'b1;   // codec runs as slave here, so unused in the datapath

    typedef struct packed {
        logic load;      // load TX shift register for the next frame
        logic shift;     // a data bit goes to the DAC pin register this cycle
        logic cap;       // ADC pin is sampled this cycle
        logic cap_last;  // this sample is the frame LSB
    } slot_ctl_t;

    function automatic int frame_clks(input int fs);
        return CLK12_HZ / fs;
    endfunction

endpackage

// File: rtl/audio_frame_timer.sv
// audio_frame_timer: slot counter and frame strobes.
//   clk_i, rst_i : clk12 and synchronous active-high reset
//   en_i         : framing enable; low aborts the frame and parks the counter at 0
//   ctl_o        : load / shift / capture strobes for the datapaths
//   lrc_o        : registered frame sync, high during pin slot 0
module audio_frame_timer
    import audio_pkg::*;
#(
    parameter int FRAME_CLKS = FS_48K_FRAME_CLKS,
    parameter int NW         = 32
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      en_i,
    output slot_ctl_t ctl_o,
    output logic      lrc_o
);

    localparam int              SW    = $clog2(FRAME_CLKS);
    localparam logic [SW-1:0]   LAST  = SW'(FRAME_CLKS - 1);
    localparam logic [SW:0]     NW_X  = (SW+1)'(NW);
    localparam logic [SW:0]     NW_M1 = (SW+1)'(NW - 1);

    logic [SW-1:0] s_q, s_d;
    logic [SW-1:0] p_q;        // slot currently shown at the pins
    logic          pin_act_q;  // pins are showing a live frame slot
    logic          lrc_q;
    logic [SW:0]   s_x, p_x;

    assign s_x = {1'b0, s_q};
    assign p_x = {1'b0, p_q};

    always_comb begin
        s_d = '0;
        if (en_i && s_q != LAST) s_d = s_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_q       <= '0;
            p_q       <= '0;
            pin_act_q <= 1'b0;
            lrc_q     <= 1'b0;
        end else begin
            s_q       <= s_d;
            p_q       <= s_q;
            pin_act_q <= en_i;
            lrc_q     <= en_i && (s_q == '0);
        end
    end

    // Capture is keyed to the pin slot (one behind s) so the ADC bit is
    // sampled at the rising edge that closes the slot it was driven in.
    always_comb begin
        ctl_o.load     = en_i && (s_q == LAST);
        ctl_o.shift    = en_i && (s_x < NW_X);
        ctl_o.cap      = en_i && pin_act_q && (p_x < NW_X);
        ctl_o.cap_last = en_i && pin_act_q && (p_x == NW_M1);
    end

    assign lrc_o = lrc_q;

endmodule

// File: rtl/audio_dsp_serdes.sv
// audio_dsp_serdes: full-duplex WM8750 DSP mode B port, codec slave, BCLK = MCLK = clk12.
//   tx_valid/tx_ready/tx_data : TX frame stream into a one-entry holding buffer
//   rx_valid/rx_data          : captured ADC frame, one-cycle valid pulse
//   underrun_cnt/underrun_clr : saturating count of frames sent without fresh data
//   audio_*                   : codec pins; all outputs except the clocks are registered
module audio_dsp_serdes
    import audio_pkg::*;
#(
    parameter int FRAME_CLKS = FS_48K_FRAME_CLKS,
    parameter int WL         = 16,
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 16
) (
    input  logic                 clk12,
    input  logic                 reset12,
    input  logic                 en,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [NUM_CH*WL-1:0] tx_data,
    output logic                 rx_valid,
    output logic [NUM_CH*WL-1:0] rx_data,
    output logic [CNT_W-1:0]     underrun_cnt,
    input  logic                 underrun_clr,
    output logic                 audio_mclk,
    output logic                 audio_bclk,
    output logic                 audio_daclrc,
    output logic                 audio_dacdat,
    output logic                 audio_adclrc,
    input  logic                 audio_adcdat
);

    localparam int NW = NUM_CH * WL;

    slot_ctl_t       ctl;
    logic            lrc;
    logic            xfer;
    logic [NW-1:0]   hold_q, hold_d, txsh_q, txsh_d, rxsh_q, rxsh_d, rx_data_q;
    logic            full_q, full_d, dacdat_q, rx_valid_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    audio_frame_timer #(.FRAME_CLKS(FRAME_CLKS), .NW(NW)) u_timer (
        .clk_i (clk12),
        .rst_i (reset12),
        .en_i  (en),
        .ctl_o (ctl),
        .lrc_o (lrc)
    );

    assign tx_ready = !full_q;
    assign xfer     = tx_valid && !full_q;

    // A transfer can only happen with the buffer empty, so it never races the
    // load draining a full buffer; one landing on the load cycle waits a frame.
    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        txsh_d = txsh_q;
        cnt_d  = cnt_q;
        if (xfer) begin
            hold_d = tx_data;
            full_d = 1'b1;
        end
        if (!en) begin
            txsh_d = '0;
        end else if (ctl.load) begin
            if (full_q) begin
                txsh_d = hold_q;
                full_d = 1'b0;
            end else begin
                txsh_d = '0;
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end
        end else if (ctl.shift) begin
            txsh_d = txsh_q << 1;
        end
        if (underrun_clr) cnt_d = '0;
    end

    assign rxsh_d = ctl.cap ? {rxsh_q[NW-2:0], audio_adcdat} : rxsh_q;

    always_ff @(posedge clk12) begin
        if (reset12) begin
            hold_q     <= '0;
            full_q     <= 1'b0;
            txsh_q     <= '0;
            cnt_q      <= '0;
            dacdat_q   <= 1'b0;
            rxsh_q     <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            full_q     <= full_d;
            txsh_q     <= txsh_d;
            cnt_q      <= cnt_d;
            dacdat_q   <= ctl.shift & txsh_q[NW-1];
            rxsh_q     <= rxsh_d;
            rx_valid_q <= ctl.cap_last;
            if (ctl.cap_last) rx_data_q <= rxsh_d;
        end
    end

    assign rx_valid     = rx_valid_q;
    assign rx_data      = rx_data_q;
    assign underrun_cnt = cnt_q;
    assign audio_mclk   = clk12;
    assign audio_bclk   = clk12;
    assign audio_daclrc = lrc;
    assign audio_adclrc = lrc;
    assign audio_dacdat = dacdat_q;

endmodule

// File: tb/tb_audio_dsp_serdes.sv
// Bench for audio_dsp_serdes: two configurations (48 kHz 2x16, 96 kHz 2x24 with
// a 4-bit underrun counter) run side by side under shared control, each against
// a frame-level reference model kept in this file.
module tb_audio_dsp_serdes;

    logic clk12 = 1'b0;
    always #5 clk12 = ~clk12;

    logic        reset12 = 1'b1;
    logic        en = 1'b0;
    logic        underrun_clr = 1'b0;
    logic        lb = 1'b1;          // 1: ADC pin looped back from DAC pin
    bit          started = 1'b0;
    bit          use_pat = 1'b0;
    int          tx_rate = 0;        // percent chance tx_valid is high per cycle
    logic [63:0] pat [2];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int WLG = (g == 0) ? 16 : 24;
        localparam int FC  = (g == 0) ? 250 : 125;
        localparam int CW  = (g == 0) ? 16 : 4;
        localparam int NW  = 2 * WLG;

        logic          tv = 1'b0;
        logic [NW-1:0] td = '0;
        logic          adc_r = 1'b0;
        logic          rdy, rxv, mclk, bclk, dlrc, ddat, alrc, adc;
        logic [NW-1:0] rxd;
        logic [CW-1:0] ucnt;

        assign adc = lb ? ddat : adc_r;

        audio_dsp_serdes #(.FRAME_CLKS(FC), .WL(WLG), .NUM_CH(2), .CNT_W(CW)) u_dut (
            .clk12        (clk12),
            .reset12      (reset12),
            .en           (en),
            .tx_valid     (tv),
            .tx_ready     (rdy),
            .tx_data      (td),
            .rx_valid     (rxv),
            .rx_data      (rxd),
            .underrun_cnt (ucnt),
            .underrun_clr (underrun_clr),
            .audio_mclk   (mclk),
            .audio_bclk   (bclk),
            .audio_daclrc (dlrc),
            .audio_dacdat (ddat),
            .audio_adclrc (alrc),
            .audio_adcdat (adc)
        );

        // Reference model: frame position, pending-frame queue, and what the
        // pins should show after each edge.
        int            m_slot = 0;   // cycles into the current frame
        int            m_pin = -1;   // frame slot shown at the pins, -1 idle
        int            m_ucnt = 0;
        bit            m_lrc = 0, m_dat = 0, m_rxv = 0;
        logic [NW-1:0] m_load = '0, m_cur = '0, m_rxsh = '0, m_rxd = '0;
        logic [NW-1:0] m_hold [$];

        initial forever begin
            int  pin_old;
            bit  was_empty, undr;
            @(posedge clk12);
            if (reset12) begin
                m_slot = 0; m_pin = -1; m_ucnt = 0;
                m_lrc = 0; m_dat = 0; m_rxv = 0;
                m_load = '0; m_cur = '0; m_rxsh = '0; m_rxd = '0;
                m_hold.delete();
            end else begin
                pin_old   = m_pin;
                was_empty = (m_hold.size() == 0);
                undr      = 0;
                m_rxv     = 0;
                if (en && pin_old >= 0 && pin_old < NW) begin
                    m_rxsh = {m_rxsh[NW-2:0], adc};
                    if (pin_old == NW - 1) begin
                        m_rxv = 1;
                        m_rxd = m_rxsh;
                    end
                end
                if (!en) begin
                    m_slot = 0; m_pin = -1; m_load = '0; m_lrc = 0; m_dat = 0;
                end else begin
                    if (m_slot == 0) m_cur = m_load;
                    m_pin = m_slot;
                    m_lrc = (m_slot == 0);
                    m_dat = (m_slot < NW) ? m_cur[NW-1-m_slot] : 1'b0;
                    if (m_slot == FC - 1) begin
                        if (m_hold.size() != 0) m_load = m_hold.pop_front();
                        else begin m_load = '0; undr = 1; end
                    end
                    m_slot = (m_slot + 1) % FC;
                end
                if (tv && was_empty) m_hold.push_back(td);
                if (underrun_clr) m_ucnt = 0;
                else if (undr && m_ucnt < (1 << CW) - 1) m_ucnt++;
            end
        end

        initial forever begin
            @(negedge clk12);
            tv    = ($urandom_range(99) < tx_rate);
            td    = use_pat ? pat[g][NW-1:0] : NW'({$urandom(), $urandom()});
            adc_r = 1'($urandom_range(1));
        end

        initial forever begin
            @(negedge clk12);
            if (started) begin
                chk($sformatf("c%0d_daclrc", g), 64'(dlrc), 64'(m_lrc));
                chk($sformatf("c%0d_adclrc", g), 64'(alrc), 64'(m_lrc));
                chk($sformatf("c%0d_dacdat", g), 64'(ddat), 64'(m_dat));
                chk($sformatf("c%0d_tx_ready", g), 64'(rdy), 64'(m_hold.size() == 0));
                chk($sformatf("c%0d_rx_valid", g), 64'(rxv), 64'(m_rxv));
                chk($sformatf("c%0d_rx_data", g), 64'(rxd), 64'(m_rxd));
                chk($sformatf("c%0d_underrun", g), 64'(ucnt), 64'(m_ucnt));
            end
        end
    end

    initial begin
        bit found;
        pat[0] = '0;
        pat[1] = '0;
        @(posedge clk12);
        started = 1'b1;
        repeat (3) @(negedge clk12);
        chk("rst_tx_ready", 64'(cfg[0].rdy), 64'd1);
        chk("rst_underrun", 64'(cfg[0].ucnt), 64'd0);
        chk("rst_rx_data", 64'(cfg[0].rxd), 64'd0);

        // idle TX: zero frames, one underrun per frame
        reset12 = 1'b0;
        en = 1'b1;
        repeat (750) @(posedge clk12);
        @(negedge clk12);
        chk("urun_3frames", 64'(cfg[0].ucnt), 64'd3);
        chk("urun_6frames_96k", 64'(cfg[1].ucnt), 64'd6);

        // fixed patterns, buffer kept full: no new underruns
        use_pat = 1'b1;
        pat[0]  = 64'hE000_FC00;
        pat[1]  = 64'h8000_017F_FFFF;
        tx_rate = 100;
        repeat (750) @(negedge clk12);
        chk("pat_urun", 64'(cfg[0].ucnt), 64'd3);
        chk("pat_urun_96k", 64'(cfg[1].ucnt), 64'd6);
        chk("loop_rx_e000", 64'(cfg[0].rxd), 64'hE000_FC00);
        chk("loop_rx_96k", 64'(cfg[1].rxd), 64'h8000_017F_FFFF);

        pat[0] = 64'h1234_ABCD;
        repeat (750) @(negedge clk12);
        chk("loop_rx_1234", 64'(cfg[0].rxd), 64'h1234_ABCD);

        // random traffic, random ADC data, en drops, clears, one mid-frame reset
        use_pat = 1'b0;
        for (int i = 0; i < 30; i++) begin
            en = 1'b1;
            lb = 1'($urandom_range(1));
            tx_rate = $urandom_range(100);
            repeat ($urandom_range(700, 50)) begin
                @(negedge clk12);
                underrun_clr = ($urandom_range(49) == 0);
            end
            underrun_clr = 1'b0;
            if (i % 10 == 5) begin
                reset12 = 1'b1;
                @(negedge clk12);
                reset12 = 1'b0;
            end
            en = 1'b0;
            repeat ($urandom_range(4, 1)) @(negedge clk12);
        end

        // en dropped in pin slot 10, then re-enabled
        en = 1'b1;
        lb = 1'b1;
        use_pat = 1'b1;
        tx_rate = 100;
        found = 0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk12);
            if (cfg[0].m_pin == 10) found = 1;
        end
        chk("drop_slot10_reached", 64'(found), 64'd1);
        en = 1'b0;
        @(negedge clk12);
        chk("drop_dacdat", 64'(cfg[0].ddat), 64'd0);
        chk("drop_lrc", 64'(cfg[0].dlrc), 64'd0);
        en = 1'b1;
        @(negedge clk12);
        chk("reen_lrc", 64'(cfg[0].dlrc), 64'd1);
        repeat (600) @(negedge clk12);

        // saturation on the 4-bit counter, then clear across frame loads
        tx_rate = 0;
        repeat (2500) @(negedge clk12);
        chk("urun_saturate", 64'(cfg[1].ucnt), 64'hF);
        underrun_clr = 1'b1;
        repeat (300) @(negedge clk12);
        chk("urun_clr", 64'(cfg[0].ucnt), 64'd0);
        chk("urun_clr_96k", 64'(cfg[1].ucnt), 64'd0);
        underrun_clr = 1'b0;
        repeat (10) @(negedge clk12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
